// File: rtl/text_console_writer.sv
// Text console writer: turns a stream of character codes into cell writes for a
// COLS x ROWS text buffer, handling cursor movement, control codes, line clear
// on row advance and full-screen clear.
//
// Ports:
//   clock       rising-edge clock for all state
//   reset       synchronous active-low reset
//   char_valid  a character is offered
//   char_data   character code
//   char_attr   attribute {fg[2:0], bg[2:0]}
//   char_ready  high only in IDLE; transfer = char_valid & char_ready
//   waddr       cell address row*COLS+col
//   wdata       cell word {2'b00, fg, bg, glyph}
//   wenable     one-cycle write strobe
//   cursor_col  current cursor column
//   cursor_row  current cursor row
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | char_ready high, waiting for a character
// PUT        | cycle after acceptance; carries the cell write, if any
// CLR_LINE   | blanking the row just advanced into, one cell per cycle
// CLR_SCREEN | blanking the whole buffer, one cell per cycle
module text_console_writer #(
    parameter int         COLS           = 100,
    parameter int         ROWS           = 60,
    parameter logic [5:0] DEFAULT_ATTR   = 6'b111000,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    input  logic [5:0]  char_attr,
    output logic        char_ready,
    output logic [15:0] waddr,
    output logic [15:0] wdata,
    output logic        wenable,
    output logic [6:0]  cursor_col,
    output logic [5:0]  cursor_row
);

    typedef enum logic [1:0] {IDLE, PUT, CLR_LINE, CLR_SCREEN} state_t;

    localparam logic [15:0] COLS16    = 16'(COLS);
    localparam logic [15:0] LAST_CELL = 16'(COLS * ROWS - 1);
    localparam logic [6:0]  COL_LAST  = 7'(COLS - 1);
    localparam logic [5:0]  ROW_LAST  = 6'(ROWS - 1);
    localparam logic [7:0]  SPACE     = 8'h20;

    state_t      state, state_next;
    logic        init_done, init_done_next;
    logic        line_pend, line_pend_next;
    logic        screen_pend, screen_pend_next;
    logic [5:0]  attr, attr_next;
    logic [15:0] clr_end, clr_end_next;
    logic [15:0] waddr_next, wdata_next;
    logic        wenable_next, char_ready_next;
    logic [6:0]  col_next;
    logic [5:0]  row_next, row_adv;
    logic [15:0] line_base;

    function automatic logic [15:0] cell_addr(input logic [5:0] r, input logic [6:0] c);
        return 16'(r) * COLS16 + 16'(c);
    endfunction

    assign row_adv   = (cursor_row == ROW_LAST) ? 6'd0 : cursor_row + 6'd1;
    assign line_base = cell_addr(cursor_row, 7'd0);

    always_comb begin
        state_next       = state;
        init_done_next   = 1'b1;
        line_pend_next   = line_pend;
        screen_pend_next = screen_pend;
        attr_next        = attr;
        clr_end_next     = clr_end;
        waddr_next       = waddr;
        wdata_next       = wdata;
        wenable_next     = 1'b0;
        char_ready_next  = 1'b0;
        col_next         = cursor_col;
        row_next         = cursor_row;

        if (!init_done) begin
            // First edge out of reset: either kick off the screen clear or go ready.
            if (CLEAR_ON_RESET) begin
                state_next   = CLR_SCREEN;
                attr_next    = DEFAULT_ATTR;
                wenable_next = 1'b1;
                waddr_next   = 16'd0;
                wdata_next   = {2'b00, DEFAULT_ATTR, SPACE};
                clr_end_next = LAST_CELL;
            end else begin
                state_next      = IDLE;
                char_ready_next = 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    char_ready_next = 1'b1;
                    if (char_valid && char_ready) begin
                        // Outputs are registered, so the PUT-cycle write is set up here.
                        char_ready_next  = 1'b0;
                        state_next       = PUT;
                        attr_next        = char_attr;
                        line_pend_next   = 1'b0;
                        screen_pend_next = 1'b0;
                        if (char_data >= 8'h20) begin
                            wenable_next = 1'b1;
                            waddr_next   = cell_addr(cursor_row, cursor_col);
                            wdata_next   = {2'b00, char_attr, char_data};
                            if (cursor_col == COL_LAST) begin
                                col_next       = 7'd0;
                                row_next       = row_adv;
                                line_pend_next = 1'b1;
                            end else begin
                                col_next = cursor_col + 7'd1;
                            end
                        end else begin
                            case (char_data)
                                8'h0A: begin
                                    col_next       = 7'd0;
                                    row_next       = row_adv;
                                    line_pend_next = 1'b1;
                                end
                                8'h0D: col_next = 7'd0;
                                8'h08: begin
                                    if (cursor_col != 7'd0) begin
                                        col_next     = cursor_col - 7'd1;
                                        wenable_next = 1'b1;
                                        waddr_next   = cell_addr(cursor_row, cursor_col - 7'd1);
                                        wdata_next   = {2'b00, char_attr, SPACE};
                                    end
                                end
                                8'h0C: begin
                                    col_next         = 7'd0;
                                    row_next         = 6'd0;
                                    screen_pend_next = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                PUT: begin
                    // Row was already advanced at acceptance, so line_base is the new row.
                    if (line_pend) begin
                        state_next   = CLR_LINE;
                        wenable_next = 1'b1;
                        waddr_next   = line_base;
                        wdata_next   = {2'b00, attr, SPACE};
                        clr_end_next = line_base + COLS16 - 16'd1;
                    end else if (screen_pend) begin
                        state_next   = CLR_SCREEN;
                        wenable_next = 1'b1;
                        waddr_next   = 16'd0;
                        wdata_next   = {2'b00, attr, SPACE};
                        clr_end_next = LAST_CELL;
                    end else begin
                        state_next      = IDLE;
                        char_ready_next = 1'b1;
                    end
                end
                CLR_LINE, CLR_SCREEN: begin
                    // waddr doubles as the clear counter; the write visible now is at waddr.
                    if (waddr == clr_end) begin
                        state_next      = IDLE;
                        char_ready_next = 1'b1;
                    end else begin
                        wenable_next = 1'b1;
                        waddr_next   = waddr + 16'd1;
                        wdata_next   = {2'b00, attr, SPACE};
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            init_done   <= 1'b0;
            line_pend   <= 1'b0;
            screen_pend <= 1'b0;
            attr        <= 6'd0;
            clr_end     <= 16'd0;
            waddr       <= 16'd0;
            wdata       <= 16'd0;
            wenable     <= 1'b0;
            char_ready  <= 1'b0;
            cursor_col  <= 7'd0;
            cursor_row  <= 6'd0;
        end else begin
            state       <= state_next;
            init_done   <= init_done_next;
            line_pend   <= line_pend_next;
            screen_pend <= screen_pend_next;
            attr        <= attr_next;
            clr_end     <= clr_end_next;
            waddr       <= waddr_next;
            wdata       <= wdata_next;
            wenable     <= wenable_next;
            char_ready  <= char_ready_next;
            cursor_col  <= col_next;
            cursor_row  <= row_next;
        end
    end

endmodule
